mem_port_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 32 +++
 rtl/mem_arb_tag_fifo.sv | 55 +++++
 rtl/mem_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and arbitration helper for mem_port_arbiter.
// The master id type is sized for the largest supported NREQ (8).
package mem_arb_pkg;

   localparam int unsigned NREQ_MAX = 8;
   localparam int unsigned ID_W     = $clog2(NREQ_MAX);

   typedef logic [ID_W-1:0] mst_id_t;

   typedef enum logic [0:0] {ST_IDLE, ST_LOCKED} arb_state_e;

   // One-hot winner: first set bit of req searching upward from start, wrapping at nreq.
   function automatic logic [NREQ_MAX-1:0] pick_winner(input logic [NREQ_MAX-1:0] req,
                                                       input mst_id_t             start,
                                                       input int unsigned         nreq);
      logic [NREQ_MAX-1:0] oh;
      logic                found;
      int unsigned         idx;
      oh    = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < NREQ_MAX; i++) begin
         idx = 32'(start) + i;
         if (idx >= nreq) idx = idx - nreq;
         if ((i < nreq) && !found && req[mst_id_t'(idx)]) begin
            oh[mst_id_t'(idx)] = 1'b1;
            found              = 1'b1;
         end
      end
      return oh;
   endfunction

endpackage

// File: rtl/mem_arb_tag_fifo.sv
// In-order FIFO of master ids for outstanding reads; pointers wrap at DEPTH.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module mem_arb_tag_fifo
   import mem_arb_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic    clk_i,
   input  logic    arst_n_i,
   input  logic    push_i,
   input  logic    pop_i,
   input  mst_id_t data_i,
   output mst_id_t data_o,
   output logic    full_o,
   output logic    empty_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [PTR_W:0]   cnt_q, cnt_d;
   mst_id_t          mem_q [DEPTH];
   logic             do_push, do_pop;

   assign full_o  = (cnt_q == (PTR_W+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);
   assign data_o  = mem_q[rptr_q];

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
      if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
      else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
         if (do_push) mem_q[wptr_q] <= data_i;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory slave port among NREQ masters and routes in-order read responses back.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration (default: fixed, lowest index wins).
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned NREQ      = 3,
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned MAX_OUTST = 4
) (
   input  logic                     clk_i,
   input  logic                     arst_n_i,
   input  logic [NREQ-1:0]          m_req_i,
   input  logic [NREQ-1:0]          m_we_i,
   input  logic [NREQ*ADDR_W-1:0]   m_addr_bi,
   input  logic [NREQ*DATA_W/8-1:0] m_be_bi,
   input  logic [NREQ*DATA_W-1:0]   m_wdata_bi,
   output logic [NREQ-1:0]          m_ack_o,
   output logic [NREQ-1:0]          m_resp_o,
   output logic [DATA_W-1:0]        m_rdata_bo,
   output logic                     s_req_o,
   output logic                     s_we_o,
   output logic [ADDR_W-1:0]        s_addr_bo,
   output logic [DATA_W/8-1:0]      s_be_bo,
   output logic [DATA_W-1:0]        s_wdata_bo,
   input  logic                     s_ack_i,
   input  logic                     s_resp_i,
   input  logic [DATA_W-1:0]        s_rdata_bi,
   output logic                     err_o
);

   localparam int unsigned BE_W = DATA_W / 8;

   arb_state_e          state_q, state_d;
   mst_id_t             grant_id_q, grant_id_d;
   mst_id_t             start_id, win_id, sel_id, head_id;
   logic [NREQ_MAX-1:0] win_oh;
   logic [NREQ-1:0]     eligible;
   logic                sel_req, accept, push, pop, blocked;
   logic                fifo_full, fifo_empty;
   logic                err_q, err_d;

   // A full FIFO only blocks reads when no response frees a slot this cycle.
   assign pop      = s_resp_i & ~fifo_empty;
   assign blocked  = fifo_full & ~pop;
   assign eligible = m_req_i & ~(~m_we_i & {NREQ{blocked}});
   assign win_oh   = pick_winner(NREQ_MAX'(eligible), start_id, NREQ);

   always_comb begin
      win_id = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         if (win_oh[k]) win_id = mst_id_t'(k);
      end
   end

   always_comb begin
      state_d    = state_q;
      grant_id_d = grant_id_q;
      sel_id     = win_id;
      sel_req    = |win_oh;
      unique case (state_q)
         ST_IDLE: begin
            if (sel_req && !s_ack_i) begin
               state_d    = ST_LOCKED;
               grant_id_d = win_id;
            end
         end
         ST_LOCKED: begin
            sel_id  = grant_id_q;
            sel_req = 1'b0;
            for (int unsigned k = 0; k < NREQ; k++) begin
               if (grant_id_q == mst_id_t'(k)) sel_req = m_req_i[k];
            end
            if (!sel_req || s_ack_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (!arst_n_i) sel_req = 1'b0;
   end

   assign accept = sel_req & s_ack_i;
   assign push   = accept & ~s_we_o;

   always_comb begin
      s_req_o    = sel_req;
      s_we_o     = 1'b0;
      s_addr_bo  = '0;
      s_be_bo    = '0;
      s_wdata_bo = '0;
      m_ack_o    = '0;
      m_resp_o   = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         if (sel_req && (sel_id == mst_id_t'(k))) begin
            s_we_o     = m_we_i[k];
            s_addr_bo  = m_addr_bi[k*ADDR_W +: ADDR_W];
            s_be_bo    = m_be_bi[k*BE_W +: BE_W];
            s_wdata_bo = m_wdata_bi[k*DATA_W +: DATA_W];
            m_ack_o[k] = s_ack_i;
         end
         if (pop && (head_id == mst_id_t'(k))) m_resp_o[k] = 1'b1;
      end
   end

   assign m_rdata_bo = pop ? s_rdata_bi : '0;
   assign err_d      = err_q | (s_resp_i & fifo_empty);
   assign err_o      = err_q;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   mst_id_t rr_q, rr_d;

   // Pointer holds the next search start; it moves only on an accepted transfer.
   always_comb begin
      rr_d = rr_q;
      if (accept) rr_d = ((32'(sel_id) + 1) >= NREQ) ? '0 : sel_id + 1'b1;
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) rr_q <= '0;
      else           rr_q <= rr_d;
   end

   assign start_id = rr_q;
`else
   assign start_id = '0;
`endif

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         state_q    <= ST_IDLE;
         grant_id_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_id_q <= grant_id_d;
         err_q      <= err_d;
      end
   end

   mem_arb_tag_fifo #(
      .DEPTH (MAX_OUTST)
   ) u_tag_fifo (
      .clk_i    (clk_i),
      .arst_n_i (arst_n_i),
      .push_i   (push),
      .pop_i    (pop),
      .data_i   (sel_id),
      .data_o   (head_id),
      .full_o   (fifo_full),
      .empty_o  (fifo_empty)
   );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        arst_n = 1'b0;
   logic [2:0]  m_req = '0, m_we = '0;
   logic [95:0] m_addr = '0, m_wdata = '0;
   logic [11:0] m_be = '0;
   logic [2:0]  m_ack, m_resp;
   logic [31:0] m_rdata;
   logic        s_req, s_we, s_ack = 1'b0, s_resp = 1'b0, err;
   logic [31:0] s_addr, s_wdata, s_rdata = '0;
   logic [3:0]  s_be;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .NREQ(3), .ADDR_W(32), .DATA_W(32), .MAX_OUTST(4)
   ) dut (
      .clk_i(clk), .arst_n_i(arst_n),
      .m_req_i(m_req), .m_we_i(m_we), .m_addr_bi(m_addr), .m_be_bi(m_be),
      .m_wdata_bi(m_wdata), .m_ack_o(m_ack), .m_resp_o(m_resp), .m_rdata_bo(m_rdata),
      .s_req_o(s_req), .s_we_o(s_we), .s_addr_bo(s_addr), .s_be_bo(s_be),
      .s_wdata_bo(s_wdata), .s_ack_i(s_ack), .s_resp_i(s_resp), .s_rdata_bi(s_rdata),
      .err_o(err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_m(input int k, input logic r, input logic w, input logic [31:0] a);
      m_req[k]             = r;
      m_we[k]              = w;
      m_addr[k*32 +: 32]   = a;
      m_be[k*4 +: 4]       = 4'hF;
      m_wdata[k*32 +: 32]  = ~a;
   endtask

   task automatic clear_inputs();
      m_req = '0; m_we = '0; m_addr = '0; m_be = '0; m_wdata = '0;
      s_ack = 1'b0; s_resp = 1'b0; s_rdata = '0;
   endtask

   task automatic apply_reset();
      clear_inputs();
      #2 arst_n = 1'b0;
      tick();
      tick();
      #2 arst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      clear_inputs();
      arst_n = 1'b0;
      s_resp = 1'b1;
      s_rdata = 32'hABCD_0123;
      #3;
      total++; if (m_ack !== 3'b000) begin bad++; $display("FAIL reset_ack got=%b exp=000", m_ack); end
      total++; if (m_resp !== 3'b000) begin bad++; $display("FAIL reset_resp got=%b exp=000", m_resp); end
      total++; if (m_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", m_rdata); end
      total++; if (s_req !== 1'b0) begin bad++; $display("FAIL reset_sreq got=%b exp=0", s_req); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
      total++; if (s_addr !== 32'h0) begin bad++; $display("FAIL reset_saddr got=%h exp=0", s_addr); end
      apply_reset();
   endtask

   task automatic test_single_read();
      apply_reset();
      set_m(1, 1'b1, 1'b0, 32'h100);
      s_ack = 1'b1;
      #2;
      total++; if (m_ack !== 3'b010) begin bad++; $display("FAIL single_ack got=%b exp=010", m_ack); end
      total++; if (s_addr !== 32'h100) begin bad++; $display("FAIL single_addr got=%h exp=100", s_addr); end
      total++; if (s_we !== 1'b0) begin bad++; $display("FAIL single_we got=%b exp=0", s_we); end
      tick();
      set_m(1, 1'b0, 1'b0, 32'h0);
      s_ack = 1'b0;
      #2;
      total++; if (m_resp !== 3'b000) begin bad++; $display("FAIL single_early_resp got=%b exp=000", m_resp); end
      tick();
      s_resp = 1'b1;
      s_rdata = 32'hDEAD_BEEF;
      #2;
      total++; if (m_resp !== 3'b010) begin bad++; $display("FAIL single_resp got=%b exp=010", m_resp); end
      total++; if (m_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL single_rdata got=%h exp=deadbeef", m_rdata); end
      tick();
      clear_inputs();
   endtask

   task automatic test_stall_lock();
      int          first, second;
      logic [31:0] addr[3];
      logic [2:0]  exp;
      addr[0] = 32'h0000_1000; addr[1] = 32'h0; addr[2] = 32'h0000_2000;
      apply_reset();
      // Master 0 write makes master 0 the last accepted master.
      set_m(0, 1'b1, 1'b1, 32'h44);
      s_ack = 1'b1;
      #2;
      total++; if (m_ack !== 3'b001) begin bad++; $display("FAIL stall_pre_ack got=%b exp=001", m_ack); end
      tick();
      s_ack = 1'b0;
      set_m(0, 1'b1, 1'b0, addr[0]);
      set_m(2, 1'b1, 1'b0, addr[2]);
      first  = RR ? 2 : 0;
      second = RR ? 0 : 2;
      for (int c = 0; c < 4; c++) begin
         s_ack = (c == 3);
         #2;
         total++;
         if (s_addr !== addr[first]) begin
            bad++; $display("FAIL stall_addr cyc=%0d got=%h exp=%h", c, s_addr, addr[first]);
         end
         exp = '0;
         if (c == 3) exp[first] = 1'b1;
         total++; if (m_ack !== exp) begin bad++; $display("FAIL stall_ack cyc=%0d got=%b exp=%b", c, m_ack, exp); end
         tick();
      end
      set_m(first, 1'b0, 1'b0, 32'h0);
      s_ack = 1'b1;
      #2;
      exp = '0; exp[second] = 1'b1;
      total++; if (m_ack !== exp) begin bad++; $display("FAIL stall_second_ack got=%b exp=%b", m_ack, exp); end
      tick();
      clear_inputs();
      s_resp = 1'b1;
      #2;
      exp = '0; exp[first] = 1'b1;
      total++; if (m_resp !== exp) begin bad++; $display("FAIL stall_resp1 got=%b exp=%b", m_resp, exp); end
      tick();
      #2;
      exp = '0; exp[second] = 1'b1;
      total++; if (m_resp !== exp) begin bad++; $display("FAIL stall_resp2 got=%b exp=%b", m_resp, exp); end
      tick();
      clear_inputs();
   endtask

   task automatic test_fifo_full();
      int         order[4];
      int         after[4];
      logic [2:0] exp;
      order[0] = 2; order[1] = 1; order[2] = 2; order[3] = 0;
      after[0] = 1; after[1] = 2; after[2] = 0; after[3] = 0;
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         m_req = '0;
         set_m(order[i], 1'b1, 1'b0, 32'h200 + 32'(i));
         s_ack = 1'b1;
         #2;
         exp = '0; exp[order[i]] = 1'b1;
         total++; if (m_ack !== exp) begin bad++; $display("FAIL full_fill_ack i=%0d got=%b exp=%b", i, m_ack, exp); end
         tick();
      end
      clear_inputs();
      set_m(0, 1'b1, 1'b0, 32'h300);
      s_ack = 1'b1;
      #2;
      total++; if (s_req !== 1'b0) begin bad++; $display("FAIL full_read_blocked got=%b exp=0", s_req); end
      total++; if (m_ack !== 3'b000) begin bad++; $display("FAIL full_read_ack got=%b exp=000", m_ack); end
      tick();
      set_m(1, 1'b1, 1'b1, 32'h400);
      #2;
      total++; if (m_ack !== 3'b010) begin bad++; $display("FAIL full_write_ack got=%b exp=010", m_ack); end
      total++; if (s_we !== 1'b1) begin bad++; $display("FAIL full_write_we got=%b exp=1", s_we); end
      total++; if (s_addr !== 32'h400) begin bad++; $display("FAIL full_write_addr got=%h exp=400", s_addr); end
      tick();
      set_m(1, 1'b0, 1'b0, 32'h0);
      s_resp = 1'b1;
      #2;
      total++; if (m_resp !== 3'b100) begin bad++; $display("FAIL full_pushpop_resp got=%b exp=100", m_resp); end
      total++; if (m_ack !== 3'b001) begin bad++; $display("FAIL full_pushpop_ack got=%b exp=001", m_ack); end
      tick();
      clear_inputs();
      s_resp = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #2;
         exp = '0; exp[after[i]] = 1'b1;
         total++; if (m_resp !== exp) begin bad++; $display("FAIL full_drain i=%0d got=%b exp=%b", i, m_resp, exp); end
         tick();
      end
      s_resp = 1'b0;
      #2;
      total++; if (err !== 1'b0) begin bad++; $display("FAIL full_err got=%b exp=0", err); end
      tick();
   endtask

   task automatic test_err();
      apply_reset();
      s_resp = 1'b1;
      s_rdata = 32'h1234_5678;
      #2;
      total++; if (m_resp !== 3'b000) begin bad++; $display("FAIL err_resp got=%b exp=000", m_resp); end
      tick();
      s_resp = 1'b0;
      #2;
      total++; if (err !== 1'b1) begin bad++; $display("FAIL err_set got=%b exp=1", err); end
      tick(); tick(); tick();
      total++; if (err !== 1'b1) begin bad++; $display("FAIL err_held got=%b exp=1", err); end
   endtask

   task automatic test_async_reset();
      apply_reset();
      for (int k = 0; k < 2; k++) begin
         m_req = '0;
         set_m(k, 1'b1, 1'b0, 32'h500 + 32'(k));
         s_ack = 1'b1;
         tick();
      end
      m_req = '0;
      s_ack = 1'b0;
      set_m(2, 1'b1, 1'b0, 32'h600);
      #2;
      total++; if (s_req !== 1'b1) begin bad++; $display("FAIL arst_pre_sreq got=%b exp=1", s_req); end
      tick();
      // Inputs stay active while reset is asserted between clock edges.
      #2;
      s_ack = 1'b1;
      s_resp = 1'b1;
      arst_n = 1'b0;
      #1;
      total++; if (s_req !== 1'b0) begin bad++; $display("FAIL arst_sreq got=%b exp=0", s_req); end
      total++; if (m_ack !== 3'b000) begin bad++; $display("FAIL arst_ack got=%b exp=000", m_ack); end
      total++; if (m_resp !== 3'b000) begin bad++; $display("FAIL arst_resp got=%b exp=000", m_resp); end
      total++; if (s_addr !== 32'h0) begin bad++; $display("FAIL arst_addr got=%h exp=0", s_addr); end
      tick();
      #2 arst_n = 1'b1;
      clear_inputs();
      tick();
      s_resp = 1'b1;
      #2;
      total++; if (m_resp !== 3'b000) begin bad++; $display("FAIL arst_stale_resp got=%b exp=000", m_resp); end
      tick();
      s_resp = 1'b0;
      set_m(1, 1'b1, 1'b1, 32'h700);
      s_ack = 1'b1;
      #2;
      total++; if (err !== 1'b1) begin bad++; $display("FAIL arst_err got=%b exp=1", err); end
      total++; if (m_ack !== 3'b010) begin bad++; $display("FAIL arst_next_ack got=%b exp=010", m_ack); end
      tick();
      clear_inputs();
   endtask

   task automatic test_random();
      int          q[$];
      int          locked, nstart, exp_m;
      bit          act[3];
      bit          full_eff;
      logic [2:0]  exp_ack, exp_resp;
      logic [31:0] rd;
      apply_reset();
      locked = -1;
      nstart = 0;
      for (int k = 0; k < 3; k++) act[k] = 1'b0;
      for (int c = 0; c < 400; c++) begin
         for (int k = 0; k < 3; k++) begin
            if (!act[k] && ($urandom_range(0, 2) == 0)) begin
               act[k] = 1'b1;
               set_m(k, 1'b1, 1'($urandom_range(0, 1)), $urandom);
            end
         end
         s_ack    = 1'($urandom_range(0, 1));
         s_resp   = (q.size() > 0) && ($urandom_range(0, 2) == 0);
         rd       = $urandom;
         s_rdata  = rd;
         full_eff = (q.size() == 4) && !s_resp;
         exp_m    = -1;
         if (locked >= 0) exp_m = locked;
         else begin
            for (int i = 0; i < 3; i++) begin
               int idx;
               idx = (nstart + i) % 3;
               if (exp_m < 0 && act[idx] && !(!m_we[idx] && full_eff)) exp_m = idx;
            end
         end
         exp_ack = '0;
         if (exp_m >= 0 && s_ack) exp_ack[exp_m] = 1'b1;
         exp_resp = '0;
         if (s_resp) exp_resp[q[0]] = 1'b1;
         #2;
         total++;
         if (s_req !== (exp_m >= 0)) begin
            bad++; $display("FAIL rand_sreq cyc=%0d got=%b exp=%b", c, s_req, exp_m >= 0);
         end
         if (exp_m >= 0) begin
            total++;
            if (s_addr !== m_addr[exp_m*32 +: 32] || s_we !== m_we[exp_m]) begin
               bad++;
               $display("FAIL rand_fields cyc=%0d got=%h/%b exp=%h/%b", c, s_addr, s_we,
                        m_addr[exp_m*32 +: 32], m_we[exp_m]);
            end
         end
         total++;
         if (m_ack !== exp_ack) begin bad++; $display("FAIL rand_ack cyc=%0d got=%b exp=%b", c, m_ack, exp_ack); end
         total++;
         if (m_resp !== exp_resp) begin bad++; $display("FAIL rand_resp cyc=%0d got=%b exp=%b", c, m_resp, exp_resp); end
         if (s_resp) begin
            total++;
            if (m_rdata !== rd) begin bad++; $display("FAIL rand_rdata cyc=%0d got=%h exp=%h", c, m_rdata, rd); end
         end
         total++;
         if (err !== 1'b0) begin bad++; $display("FAIL rand_err cyc=%0d got=%b exp=0", c, err); end
         tick();
         if (s_resp) void'(q.pop_front());
         if (exp_m >= 0) begin
            if (s_ack) begin
               if (!m_we[exp_m]) q.push_back(exp_m);
               if (RR) nstart = (exp_m + 1) % 3;
               locked = -1;
               act[exp_m] = 1'b0;
               set_m(exp_m, 1'b0, 1'b0, 32'h0);
            end else begin
               locked = exp_m;
            end
         end
      end
      clear_inputs();
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_stall_lock();
      test_fifo_full();
      test_err();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
